// File: rtl/regfile_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_if : register-file bus (write, two reads, debug, status)     |
// | Revision   : 1.0                                                     |
// +--------------------------------------------------------------------+
interface regfile_if #(
  parameter int CNT_W = 16
);
  logic             ctrl_writeEnable;
  logic [4:0]       ctrl_writeReg;
  logic [31:0]      data_writeReg;
  logic [4:0]       ctrl_readRegA;
  logic [4:0]       ctrl_readRegB;
  logic [31:0]      data_readRegA;
  logic [31:0]      data_readRegB;
  logic [4:0]       dbg_reg;
  logic [31:0]      dbg_data;
  logic [31:0]      written_mask;
  logic [CNT_W-1:0] write_count;

  modport master (
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    output ctrl_readRegA, ctrl_readRegB, dbg_reg,
    input  data_readRegA, data_readRegB, dbg_data,
    input  written_mask, write_count
  );

  modport slave (
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    input  ctrl_readRegA, ctrl_readRegB, dbg_reg,
    output data_readRegA, data_readRegB, dbg_data,
    output written_mask, write_count
  );
endinterface
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile : 31x32 architectural registers (r0 hardwired to zero),      |
// |           2 combinational read ports with optional write bypass,     |
// |           debug read port, written mask and saturating write count.  |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
module regfile #(
  parameter int BYPASS = 1,
  parameter int CNT_W  = 16
) (
  input  wire logic clock,
  input  wire logic reset,
  regfile_if.slave  bus
);

  localparam logic [CNT_W-1:0] c_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_SAT  = {CNT_W{1'b1}};

  logic        w_commit;
  logic [31:0] w_regs [32];
  logic [31:0] w_rd_a;
  logic [31:0] w_rd_b;
  logic [31:0] r_mask;
  logic [CNT_W-1:0] r_count;

  assign w_commit  = bus.ctrl_writeEnable && (bus.ctrl_writeReg != 5'd0);
  assign w_regs[0] = 32'h0000_0000;

  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_reg
      logic [31:0] r_q;
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_q <= 32'h0000_0000;
        end else if (w_commit && (bus.ctrl_writeReg == 5'(gi))) begin
          r_q <= bus.data_writeReg;
        end
      end
      assign w_regs[gi] = r_q;
    end
  endgenerate

  // w_commit already excludes index 0, so a bypass never hits r0
  always_comb begin
    w_rd_a = w_regs[bus.ctrl_readRegA];
    if ((BYPASS != 0) && w_commit && (bus.ctrl_writeReg == bus.ctrl_readRegA)) begin
      w_rd_a = bus.data_writeReg;
    end
  end

  always_comb begin
    w_rd_b = w_regs[bus.ctrl_readRegB];
    if ((BYPASS != 0) && w_commit && (bus.ctrl_writeReg == bus.ctrl_readRegB)) begin
      w_rd_b = bus.data_writeReg;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mask  <= 32'h0000_0000;
      r_count <= '0;
    end else if (w_commit) begin
      r_mask[bus.ctrl_writeReg] <= 1'b1;
      if (r_count != c_SAT) begin
        r_count <= r_count + c_ONE;
      end
    end
  end

  assign bus.data_readRegA = w_rd_a;
  assign bus.data_readRegB = w_rd_b;
  assign bus.dbg_data      = w_regs[bus.dbg_reg];
  assign bus.written_mask  = r_mask;
  assign bus.write_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_regfile : directed bench for regfile (bypass, no-bypass and       |
// |              4-bit-counter instances driven in lockstep).            |
// | Revision   : 1.0                                                     |
// +--------------------------------------------------------------------+
module tb_regfile;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  regfile_if #(.CNT_W(16)) ifc ();
  regfile_if #(.CNT_W(16)) ifc_nb ();
  regfile_if #(.CNT_W(4))  ifc_sat ();

  regfile #(.BYPASS(1), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .bus(ifc.slave)
  );
  regfile #(.BYPASS(0), .CNT_W(16)) dut_nb (
    .clock(clock), .reset(reset), .bus(ifc_nb.slave)
  );
  regfile #(.BYPASS(1), .CNT_W(4)) dut_sat (
    .clock(clock), .reset(reset), .bus(ifc_sat.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_wr(input logic we, input logic [4:0] idx, input logic [31:0] d);
    ifc.ctrl_writeEnable     = we; ifc.ctrl_writeReg     = idx; ifc.data_writeReg     = d;
    ifc_nb.ctrl_writeEnable  = we; ifc_nb.ctrl_writeReg  = idx; ifc_nb.data_writeReg  = d;
    ifc_sat.ctrl_writeEnable = we; ifc_sat.ctrl_writeReg = idx; ifc_sat.data_writeReg = d;
  endtask

  task automatic set_rd(input logic [4:0] a, input logic [4:0] b, input logic [4:0] dbg);
    ifc.ctrl_readRegA     = a; ifc.ctrl_readRegB     = b; ifc.dbg_reg     = dbg;
    ifc_nb.ctrl_readRegA  = a; ifc_nb.ctrl_readRegB  = b; ifc_nb.dbg_reg  = dbg;
    ifc_sat.ctrl_readRegA = a; ifc_sat.ctrl_readRegB = b; ifc_sat.dbg_reg = dbg;
  endtask

  task automatic do_reset();
    set_wr(1'b0, 5'd0, 32'h0);
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] a, b, d;
    reset = 1'b1;
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(5'd0, 5'd0, 5'd0);
    #2;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      a = 5'($urandom_range(1, 31));
      b = 5'($urandom_range(1, 31));
      d = 5'($urandom_range(1, 31));
      set_rd(a, b, d);
      #1;
      checks++;
      if (ifc.data_readRegA !== 32'h0) begin
        errors++; $display("FAIL reset_readA idx=%0d: got %h expected 00000000", a, ifc.data_readRegA);
      end
      checks++;
      if (ifc.data_readRegB !== 32'h0) begin
        errors++; $display("FAIL reset_readB idx=%0d: got %h expected 00000000", b, ifc.data_readRegB);
      end
      checks++;
      if (ifc.dbg_data !== 32'h0) begin
        errors++; $display("FAIL reset_dbg idx=%0d: got %h expected 00000000", d, ifc.dbg_data);
      end
    end
    checks++;
    if (ifc.written_mask !== 32'h0) begin
      errors++; $display("FAIL reset_mask: got %h expected 00000000", ifc.written_mask);
    end
    checks++;
    if (ifc.write_count !== 16'd0) begin
      errors++; $display("FAIL reset_count: got %0d expected 0", ifc.write_count);
    end
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_basic();
    set_wr(1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(5'd5, 5'd5, 5'd5);
    #1;
    checks++;
    if (ifc.data_readRegA !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL basic_readA: got %h expected deadbeef", ifc.data_readRegA);
    end
    checks++;
    if (ifc.data_readRegB !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL basic_readB: got %h expected deadbeef", ifc.data_readRegB);
    end
    checks++;
    if (ifc.dbg_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL basic_dbg: got %h expected deadbeef", ifc.dbg_data);
    end
    checks++;
    if (ifc_nb.data_readRegA !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL basic_nb_readA: got %h expected deadbeef", ifc_nb.data_readRegA);
    end
    checks++;
    if (ifc.written_mask !== 32'h0000_0020) begin
      errors++; $display("FAIL basic_mask: got %h expected 00000020", ifc.written_mask);
    end
    checks++;
    if (ifc.write_count !== 16'd1) begin
      errors++; $display("FAIL basic_count: got %0d expected 1", ifc.write_count);
    end
  endtask

  task automatic test_r0_write();
    set_wr(1'b1, 5'd0, 32'h1234_5678);
    set_rd(5'd0, 5'd0, 5'd0);
    #1;
    checks++;
    if (ifc.data_readRegA !== 32'h0) begin
      errors++; $display("FAIL r0_bypassA: got %h expected 00000000", ifc.data_readRegA);
    end
    tick();
    set_wr(1'b0, 5'd0, 32'h0);
    #1;
    checks++;
    if (ifc.data_readRegB !== 32'h0) begin
      errors++; $display("FAIL r0_readB: got %h expected 00000000", ifc.data_readRegB);
    end
    checks++;
    if (ifc.dbg_data !== 32'h0) begin
      errors++; $display("FAIL r0_dbg: got %h expected 00000000", ifc.dbg_data);
    end
    checks++;
    if (ifc.written_mask !== 32'h0000_0020) begin
      errors++; $display("FAIL r0_mask: got %h expected 00000020", ifc.written_mask);
    end
    checks++;
    if (ifc.write_count !== 16'd1) begin
      errors++; $display("FAIL r0_count: got %0d expected 1", ifc.write_count);
    end
  endtask

  task automatic test_bypass();
    set_wr(1'b1, 5'd7, 32'h0000_0011);
    tick();
    set_wr(1'b1, 5'd7, 32'h0000_0022);
    set_rd(5'd7, 5'd7, 5'd7);
    #1;
    checks++;
    if (ifc.data_readRegA !== 32'h22) begin
      errors++; $display("FAIL bypass_A_before: got %h expected 00000022", ifc.data_readRegA);
    end
    checks++;
    if (ifc.data_readRegB !== 32'h22) begin
      errors++; $display("FAIL bypass_B_before: got %h expected 00000022", ifc.data_readRegB);
    end
    checks++;
    if (ifc.dbg_data !== 32'h11) begin
      errors++; $display("FAIL bypass_dbg_before: got %h expected 00000011", ifc.dbg_data);
    end
    checks++;
    if (ifc_nb.data_readRegA !== 32'h11) begin
      errors++; $display("FAIL nobypass_A_before: got %h expected 00000011", ifc_nb.data_readRegA);
    end
    tick();
    set_wr(1'b0, 5'd0, 32'h0);
    #1;
    checks++;
    if (ifc_nb.data_readRegA !== 32'h22) begin
      errors++; $display("FAIL nobypass_A_after: got %h expected 00000022", ifc_nb.data_readRegA);
    end
    checks++;
    if (ifc.dbg_data !== 32'h22) begin
      errors++; $display("FAIL bypass_dbg_after: got %h expected 00000022", ifc.dbg_data);
    end
    checks++;
    if (ifc.written_mask !== 32'h0000_00A0) begin
      errors++; $display("FAIL bypass_mask: got %h expected 000000a0", ifc.written_mask);
    end
    checks++;
    if (ifc.write_count !== 16'd3) begin
      errors++; $display("FAIL bypass_count: got %0d expected 3", ifc.write_count);
    end
  endtask

  task automatic test_saturation();
    int exp_cnt;
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      set_wr(1'b1, 5'(i), 32'h0101_0101 * 32'(i));
      tick();
      exp_cnt = (i > 15) ? 15 : i;
      checks++;
      if (ifc_sat.write_count !== 4'(exp_cnt)) begin
        errors++; $display("FAIL sat_count write=%0d: got %0d expected %0d", i, ifc_sat.write_count, exp_cnt);
      end
    end
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(5'd20, 5'd1, 5'd15);
    #1;
    checks++;
    if (ifc_sat.written_mask !== 32'h001F_FFFE) begin
      errors++; $display("FAIL sat_mask: got %h expected 001ffffe", ifc_sat.written_mask);
    end
    checks++;
    if (ifc.write_count !== 16'd20) begin
      errors++; $display("FAIL wide_count: got %0d expected 20", ifc.write_count);
    end
    checks++;
    if (ifc_sat.data_readRegA !== 32'h1414_1414) begin
      errors++; $display("FAIL sat_r20: got %h expected 14141414", ifc_sat.data_readRegA);
    end
    checks++;
    if (ifc_sat.dbg_data !== 32'h0F0F_0F0F) begin
      errors++; $display("FAIL sat_r15: got %h expected 0f0f0f0f", ifc_sat.dbg_data);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    set_wr(1'b1, 5'd3, 32'hA5A5_A5A5);
    tick();
    set_wr(1'b1, 5'd4, 32'h4444_4444);
    set_rd(5'd3, 5'd4, 5'd3);
    #1;
    checks++;
    if (ifc.dbg_data !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL mid_r3_written: got %h expected a5a5a5a5", ifc.dbg_data);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (ifc.dbg_data !== 32'h0) begin
      errors++; $display("FAIL mid_r3_cleared: got %h expected 00000000", ifc.dbg_data);
    end
    checks++;
    if (ifc.write_count !== 16'd0) begin
      errors++; $display("FAIL mid_count_cleared: got %0d expected 0", ifc.write_count);
    end
    tick();
    set_rd(5'd4, 5'd3, 5'd4);
    #1;
    checks++;
    if (ifc.dbg_data !== 32'h0) begin
      errors++; $display("FAIL mid_r4_not_written: got %h expected 00000000", ifc.dbg_data);
    end
    checks++;
    if (ifc.written_mask !== 32'h0) begin
      errors++; $display("FAIL mid_mask_in_reset: got %h expected 00000000", ifc.written_mask);
    end
    checks++;
    if (ifc.data_readRegA !== 32'h4444_4444) begin
      errors++; $display("FAIL mid_bypass_in_reset: got %h expected 44444444", ifc.data_readRegA);
    end
    reset = 1'b1;
    tick();
    set_wr(1'b0, 5'd0, 32'h0);
    #1;
    checks++;
    if (ifc.write_count !== 16'd1) begin
      errors++; $display("FAIL mid_first_count: got %0d expected 1", ifc.write_count);
    end
    checks++;
    if (ifc.dbg_data !== 32'h4444_4444) begin
      errors++; $display("FAIL mid_first_r4: got %h expected 44444444", ifc.dbg_data);
    end
    checks++;
    if (ifc.written_mask !== 32'h0000_0010) begin
      errors++; $display("FAIL mid_first_mask: got %h expected 00000010", ifc.written_mask);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_r0_write();
    test_bypass();
    test_saturation();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
